// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO round-robin write arbiter.
// Holds the arbiter state encoding and a one-hot index decoder.
package fifo_arb_pkg;

  // Widest requester vector the one-hot helper can produce.
  localparam int MAX_REQ  = 32;
  localparam int OH_IDX_W = 5;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  function automatic logic [MAX_REQ-1:0] onehot(
    input logic [OH_IDX_W-1:0] idx
  );
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fifo_rr_write_arbiter_picker.sv
// Combinational round-robin picker: first set request after last_i.
// Search order is last_i+1, last_i+2, ... wrapping modulo NUM_REQ.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   pick_o
);

  int             sum;
  logic [IDX_W-1:0] idx;

  // Scan the rotated request vector and keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    pick_o  = '0;
    sum     = 0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum = int'(last_i) + k;
      idx = IDX_W'(sum % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        valid_o = 1'b1;
        pick_o  = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin, burst-bounded arbiter for a single FIFO write port.
// Define FIFO_ARB_ALMOST_FULL_THROTTLE_EN to hold off new bursts on almost-full.
module fifo_rr_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          fifo_full_i,
  input  logic                          fifo_almost_full_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          fifo_write_o,
  output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o,
  output logic                          busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_q,  last_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [DATA_WIDTH-1:0] words [NUM_REQ];

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             start;
  logic             wr;
  logic             owner_req;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .pick_o  (pick_idx)
  );

  // Unpack the producer words so the owner can select one by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      words[i] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_ALMOST_FULL_THROTTLE_EN
  // A new burst only opens when the FIFO has comfortable headroom.
  always_comb begin
    start = pick_valid && !fifo_full_i && !fifo_almost_full_i;
  end
`else
  logic unused_af;
  assign unused_af = fifo_almost_full_i;

  // A new burst opens as soon as someone asks and the FIFO is not full.
  always_comb begin
    start = pick_valid && !fifo_full_i;
  end
`endif

  // Write-side outputs come straight from the owner's request and data.
  always_comb begin
    owner_req    = req_i[owner_q];
    wr           = 1'b0;
    grant_o      = '0;
    fifo_write_o = 1'b0;
    fifo_wdata_o = '0;
    if (state_q == BURST) begin
      wr           = owner_req && !fifo_full_i;
      fifo_write_o = wr;
      fifo_wdata_o = words[owner_q];
      if (wr) begin
        grant_o = NUM_REQ'(onehot(OH_IDX_W'(owner_q)));
      end
    end
    busy_o  = (state_q == BURST);
    owner_o = owner_q;
  end

  // Next-state: open a burst from IDLE, close it on length or request drop.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BURST;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!fifo_full_i) begin
          if (!owner_req) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d = IDLE;
              last_d  = owner_q;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset makes producer 0 the first pick.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  a_no_write_when_full : assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(fifo_write_o && fifo_full_i)
  );

  a_grant_onehot0 : assert property (
    @(posedge clk_i) disable iff (reset_i)
    $onehot0(grant_o)
  );

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Scoreboard bench for fifo_rr_write_arbiter (4 producers, 8-bit, burst 4).
// Producer queues drive req/data; a monitor checks every FIFO write.
module tb_fifo_rr_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] dat;
  } exp_t;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [NR-1:0]  req_i = '0;
  logic [NR*DW-1:0] data_i = '0;
  logic           fifo_full_i = 1'b0;
  logic           fifo_almost_full_i = 1'b0;
  logic [NR-1:0]  grant_o;
  logic           fifo_write_o;
  logic [DW-1:0]  fifo_wdata_o;
  logic [1:0]     owner_o;
  logic           busy_o;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] pq[NR][$];
  int         wr_cyc[$];
  int         cyc = 0;
  int         nwr = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         base = 0;
  logic [NR-1:0] g_q = '0;

  fifo_rr_write_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .req_i              (req_i),
    .data_i             (data_i),
    .fifo_full_i        (fifo_full_i),
    .fifo_almost_full_i (fifo_almost_full_i),
    .grant_o            (grant_o),
    .fifo_write_o       (fifo_write_o),
    .fifo_wdata_o       (fifo_wdata_o),
    .owner_o            (owner_o),
    .busy_o             (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic expw(input int o, input int d);
    exp_t x;
    x.own = 2'(o);
    x.dat = 8'(d);
    exp_q.push_back(x);
  endtask

  task automatic load(input int p, input int d);
    pq[p].push_back(8'(d));
  endtask

  // Producer side: retire granted words, then present the next one.
  always @(posedge clk_i) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (g_q[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req_i[i] = (pq[i].size() > 0);
      data_i[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0] : 8'h00;
    end
    g_q = '0;
  end

  // Monitor: every FIFO write must match the head of the scoreboard.
  always @(negedge clk_i) begin
    g_q = grant_o;
    if (fifo_write_o) begin
      nwr++;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got data %0h owner %0d, required no write",
                 fifo_wdata_o, owner_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", 32'(fifo_wdata_o), 32'(e.dat));
        chk("wr_grant", 32'(grant_o), 32'(4'b0001 << e.own));
        chk("wr_owner", 32'(owner_o), 32'(e.own));
      end
    end
  end

  task automatic wait_writes(input int n, input string nm);
    int k = 0;
    while (nwr < n && k < 80) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk({"reach_", nm}, 32'(nwr >= n), 32'd1);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 80) begin
      @(posedge clk_i);
      #2;
      k++;
    end
    chk({"drain_", nm}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk_i);
    #2;
  endtask

  task automatic gap(input string nm, input int idx, input int want);
    if (idx + 1 < wr_cyc.size()) begin
      chk(nm, 32'(wr_cyc[idx+1] - wr_cyc[idx]), 32'(want));
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got missing write %0d, required gap %0d", nm, idx + 1, want);
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    fifo_full_i = 1'b0;
    fifo_almost_full_i = 1'b0;
    for (int i = 0; i < NR; i++) pq[i].delete();
    repeat (2) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #2;
    reset_i = 1'b0;

    // 1: quiet after reset
    repeat (5) begin
      @(negedge clk_i);
      chk("idle_out", 32'({grant_o, fifo_write_o, fifo_wdata_o, busy_o, owner_o}), 32'd0);
    end
    @(posedge clk_i);
    #2;

    // 2: single producer, 6 words, two bursts
    base = nwr;
    for (int j = 0; j < 6; j++) begin
      load(2, 8'h20 + j);
      expw(2, 8'h20 + j);
    end
    @(posedge clk_i);
    #2;
    @(negedge clk_i);
    chk("s2_bubble", 32'({busy_o, fifo_write_o}), 32'd0);
    @(posedge clk_i);
    #2;
    @(negedge clk_i);
    chk("s2_first", 32'({busy_o, fifo_write_o}), 32'b11);
    @(posedge clk_i);
    #2;
    wait_writes(base + 6, "s2");
    drain("s2");
    for (int k = 0; k < 5; k++) gap("s2_gap", base + k, (k == 3) ? 2 : 1);

    // 3: all four requesting, owners 0,1,2,3,0
    do_reset();
    base = nwr;
    for (int j = 0; j < 8; j++) load(0, 8'h30 + j);
    for (int j = 0; j < 4; j++) begin
      load(1, 8'h40 + j);
      load(2, 8'h50 + j);
      load(3, 8'h60 + j);
    end
    for (int j = 0; j < 4; j++) expw(0, 8'h30 + j);
    for (int j = 0; j < 4; j++) expw(1, 8'h40 + j);
    for (int j = 0; j < 4; j++) expw(2, 8'h50 + j);
    for (int j = 0; j < 4; j++) expw(3, 8'h60 + j);
    for (int j = 4; j < 8; j++) expw(0, 8'h30 + j);
    wait_writes(base + 20, "s3");
    drain("s3");
    for (int k = 0; k < 19; k++) gap("s3_gap", base + k, ((k % 4) == 3) ? 2 : 1);

    // 4: full stall mid-burst, no re-arbitration
    do_reset();
    base = nwr;
    for (int j = 0; j < 4; j++) begin
      load(0, 8'h70 + j);
      expw(0, 8'h70 + j);
    end
    load(1, 8'h78);
    expw(1, 8'h78);
    wait_writes(base + 2, "s4a");
    fifo_full_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("s4_stall", 32'({busy_o, fifo_write_o, grant_o}), 32'b1_0_0000);
      @(posedge clk_i);
      #2;
    end
    fifo_full_i = 1'b0;
    wait_writes(base + 5, "s4b");
    drain("s4");
    gap("s4_gap01", base + 0, 1);
    gap("s4_gap12", base + 1, 4);
    gap("s4_gap23", base + 2, 1);
    gap("s4_gap34", base + 3, 2);

    // 5a: owner 1 drops after 2 words, next owner is 2
    do_reset();
    base = nwr;
    load(0, 8'h80);
    expw(0, 8'h80);
    wait_writes(base + 1, "s5a");
    repeat (3) @(posedge clk_i);
    #2;
    load(1, 8'h90);
    load(1, 8'h91);
    load(0, 8'h81);
    load(2, 8'hA0);
    expw(1, 8'h90);
    expw(1, 8'h91);
    expw(2, 8'hA0);
    expw(0, 8'h81);
    wait_writes(base + 5, "s5b");
    drain("s5a");
    gap("s5_gap12", base + 1, 1);
    gap("s5_gap23", base + 2, 3);
    gap("s5_gap34", base + 3, 3);

    // 5b: reset mid-burst, next pick is 0
    base = nwr;
    for (int j = 0; j < 4; j++) load(3, 8'hB0 + j);
    expw(3, 8'hB0);
    expw(3, 8'hB1);
    wait_writes(base + 2, "s5c");
    reset_i = 1'b1;
    #1;
    chk("s5_rst_out", 32'({grant_o, fifo_write_o, fifo_wdata_o, busy_o, owner_o}), 32'd0);
    load(0, 8'hC0);
    expw(0, 8'hC0);
    expw(3, 8'hB2);
    expw(3, 8'hB3);
    repeat (2) @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    wait_writes(base + 5, "s5d");
    drain("s5b");

    // 6: almost-full while idle
    do_reset();
    base = nwr;
    fifo_almost_full_i = 1'b1;
    load(0, 8'hD0);
    expw(0, 8'hD0);
    @(posedge clk_i);
    #2;
    @(negedge clk_i);
    chk("s6_bubble", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #2;
`ifdef FIFO_ARB_ALMOST_FULL_THROTTLE_EN
    repeat (3) begin
      @(negedge clk_i);
      chk("s6_throttle", 32'({busy_o, fifo_write_o}), 32'd0);
      @(posedge clk_i);
      #2;
    end
    fifo_almost_full_i = 1'b0;
`else
    @(negedge clk_i);
    chk("s6_start", 32'({busy_o, fifo_write_o}), 32'b11);
    @(posedge clk_i);
    #2;
    fifo_almost_full_i = 1'b0;
`endif
    wait_writes(base + 1, "s6");
    drain("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
